// File: rtl/rvfi_seq_pkg.sv
// Shared definitions for the RVFI channel sequencer: state encoding,
// fixed field widths and the packed-field offset helper.
package rvfi_seq_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } seq_state_e;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned INSN_W = 32;

    // Bit offset of channel ch within a packed per-channel vector of w-bit fields.
    function automatic int unsigned field_off(input int unsigned ch, input int unsigned w);
        return ch * w;
    endfunction

endpackage

// File: rtl/rvfi_lowest_set.sv
// Combinational priority encoder: index of the lowest set bit, a one-hot
// mask of that bit, and a flag for exactly one bit set.
module rvfi_lowest_set #(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0]                        bits,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] index,
    output logic [N-1:0]                        clear,
    output logic                                single
);
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    logic found;

    always_comb begin
        index = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (bits[i] && !found) begin
                index = IW'(i);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        clear = '0;
        if (found) begin
            clear[index] = 1'b1;
        end
    end

    // Clearing the lowest set bit leaves nothing only when exactly one was set.
    assign single = found && ((bits & (bits - N'(1))) == '0);

endmodule

// File: rtl/rvfi_channel_sequencer.sv
// Serializes an NRET-wide RVFI retirement group into a single-channel
// stream, one valid channel per beat in ascending channel order.
module rvfi_channel_sequencer
    import rvfi_seq_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NRET   = 2,
    parameter int unsigned ORDERW = 64
) (
    input  logic                                   clk,
    input  logic                                   reset,

    input  logic [NRET-1:0]                        in_valid,
    input  logic [NRET*5-1:0]                      in_rs1,
    input  logic [NRET*5-1:0]                      in_rs2,
    input  logic [NRET*5-1:0]                      in_rd,
    input  logic [NRET*32-1:0]                     in_insn,
    input  logic [NRET*XLEN-1:0]                   in_pre_pc,
    input  logic [NRET*XLEN-1:0]                   in_pre_rs1,
    input  logic [NRET*XLEN-1:0]                   in_pre_rs2,
    input  logic [NRET*XLEN-1:0]                   in_post_pc,
    input  logic [NRET*XLEN-1:0]                   in_post_rd,
    output logic                                   in_ready,

    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [4:0]                             out_rs1,
    output logic [4:0]                             out_rs2,
    output logic [4:0]                             out_rd,
    output logic [31:0]                            out_insn,
    output logic [XLEN-1:0]                        out_pre_pc,
    output logic [XLEN-1:0]                        out_pre_rs1,
    output logic [XLEN-1:0]                        out_pre_rs2,
    output logic [XLEN-1:0]                        out_post_pc,
    output logic [XLEN-1:0]                        out_post_rd,
    output logic [((NRET > 1) ? $clog2(NRET) : 1)-1:0] out_chan,
    output logic [ORDERW-1:0]                      out_order,
    output logic                                   overflow
);
    localparam int unsigned CW = (NRET > 1) ? $clog2(NRET) : 1;

    seq_state_e           state;
    logic [NRET-1:0]      pending;
    logic [NRET*5-1:0]    buf_rs1;
    logic [NRET*5-1:0]    buf_rs2;
    logic [NRET*5-1:0]    buf_rd;
    logic [NRET*32-1:0]   buf_insn;
    logic [NRET*XLEN-1:0] buf_pre_pc;
    logic [NRET*XLEN-1:0] buf_pre_rs1;
    logic [NRET*XLEN-1:0] buf_pre_rs2;
    logic [NRET*XLEN-1:0] buf_post_pc;
    logic [NRET*XLEN-1:0] buf_post_rd;
    logic [ORDERW-1:0]    order_q;
    logic                 overflow_q;

    logic [CW-1:0]        sel;
    logic [NRET-1:0]      sel_mask;
    logic                 last_beat;
    logic                 handshake;
    logic                 accept;
    int unsigned          reg_off;
    int unsigned          insn_off;
    int unsigned          xlen_off;

    rvfi_lowest_set #(.N(NRET)) u_lowest (
        .bits   (pending),
        .index  (sel),
        .clear  (sel_mask),
        .single (last_beat)
    );

    // Ready while empty, or on the final beat of a group if it is being taken now.
    assign in_ready  = (state == IDLE) || (last_beat && out_ready);
    assign out_valid = (state == ISSUE);
    assign handshake = out_valid && out_ready;
    assign accept    = in_ready && (in_valid != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pending     <= '0;
            buf_rs1     <= '0;
            buf_rs2     <= '0;
            buf_rd      <= '0;
            buf_insn    <= '0;
            buf_pre_pc  <= '0;
            buf_pre_rs1 <= '0;
            buf_pre_rs2 <= '0;
            buf_post_pc <= '0;
            buf_post_rd <= '0;
            order_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            if (handshake) begin
                order_q <= order_q + ORDERW'(1);
            end
            if (accept) begin
                state       <= ISSUE;
                pending     <= in_valid;
                buf_rs1     <= in_rs1;
                buf_rs2     <= in_rs2;
                buf_rd      <= in_rd;
                buf_insn    <= in_insn;
                buf_pre_pc  <= in_pre_pc;
                buf_pre_rs1 <= in_pre_rs1;
                buf_pre_rs2 <= in_pre_rs2;
                buf_post_pc <= in_post_pc;
                buf_post_rd <= in_post_rd;
            end else if (handshake) begin
                pending <= pending & ~sel_mask;
                state   <= last_beat ? IDLE : ISSUE;
            end
            if ((in_valid != '0) && !in_ready) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign reg_off  = field_off(32'(sel), REG_W);
    assign insn_off = field_off(32'(sel), INSN_W);
    assign xlen_off = field_off(32'(sel), XLEN);

    assign out_rs1     = buf_rs1[reg_off +: 5];
    assign out_rs2     = buf_rs2[reg_off +: 5];
    assign out_rd      = buf_rd[reg_off +: 5];
    assign out_insn    = buf_insn[insn_off +: 32];
    assign out_pre_pc  = buf_pre_pc[xlen_off +: XLEN];
    assign out_pre_rs1 = buf_pre_rs1[xlen_off +: XLEN];
    assign out_pre_rs2 = buf_pre_rs2[xlen_off +: XLEN];
    assign out_post_pc = buf_post_pc[xlen_off +: XLEN];
    assign out_post_rd = buf_post_rd[xlen_off +: XLEN];
    assign out_chan    = sel;
    assign out_order   = order_q;
    assign overflow    = overflow_q;

endmodule
